// File: rtl/special_issue_mux.sv
// Routes the channels flagged in a selection mask onto N_OUT lanes, issuing
// wide masks over several beats. Define SPECIAL_ISSUE_MUX_ERR_EN for o_error_selection.
module special_issue_mux #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int WIDTH = 32,
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N_IN-1:0]  i_selection,
  input  logic [WIDTH-1:0] i_inputs [N_IN],
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_outputs [N_OUT],
  output logic [N_OUT-1:0] o_en,
  output logic [IDX_W-1:0] o_index [N_OUT],
  output logic             o_last
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
  ,output logic            o_error_selection
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;
  localparam int CNT_W = $clog2(N_IN + 1);

  logic [0:0]       state_q, state_d;
  logic [N_IN-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0] data_q [N_IN];
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [N_OUT-1:0] en_q, en_d;
  logic [WIDTH-1:0] out_q [N_OUT];
  logic [WIDTH-1:0] out_d [N_OUT];
  logic [IDX_W-1:0] idx_q [N_OUT];
  logic [IDX_W-1:0] idx_d [N_OUT];
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
  logic             err_q, err_d;
`endif

  logic             accept;
  logic             issue_done;
  logic [N_IN-1:0]  rem_mask;
  logic [CNT_W-1:0] rem_seen;
  logic [N_IN-1:0]  src_mask;
  logic [WIDTH-1:0] src_data [N_IN];
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_last;
  logic [N_OUT-1:0] beat_en;
  logic [WIDTH-1:0] beat_out [N_OUT];
  logic [IDX_W-1:0] beat_idx [N_OUT];

  // Combinational from i_ready so a new request can follow the last beat with no bubble.
  assign o_ready = !i_rst && (state_q == ST_IDLE ||
                              (state_q == ST_ISSUE && valid_q && last_q && i_ready));
  assign accept     = i_valid && o_ready;
  assign issue_done = valid_q && i_ready;

  // Remaining mask once the lowest N_OUT set bits (the current beat) are issued.
  always_comb begin
    rem_mask = mask_q;
    rem_seen = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (mask_q[k]) begin
        if (rem_seen < CNT_W'(N_OUT)) rem_mask[k] = 1'b0;
        rem_seen = rem_seen + CNT_W'(1);
      end
    end
  end

  always_comb begin
    src_mask = accept ? i_selection : rem_mask;
    for (int k = 0; k < N_IN; k++) src_data[k] = accept ? i_inputs[k] : data_q[k];
  end

  // NOTE: blocking assignments here are intentional; beat_cnt is a running
  // count that each loop iteration must see updated by the previous one.
  always_comb begin
    beat_cnt = '0;
    beat_en  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      beat_out[j] = '0;
      beat_idx[j] = '0;
    end
    for (int k = 0; k < N_IN; k++) begin
      if (src_mask[k]) begin
        for (int j = 0; j < N_OUT; j++) begin
          if (beat_cnt == CNT_W'(j)) begin
            beat_out[j] = src_data[k];
            beat_idx[j] = IDX_W'(k);
            beat_en[j]  = 1'b1;
          end
        end
        beat_cnt = beat_cnt + CNT_W'(1);
      end
    end
    beat_last = (beat_cnt <= CNT_W'(N_OUT));
  end

  // NOTE: every _d starts from its _q so no path leaves a signal unassigned
  // (which would infer a latch); holding is the default, giving stall stability.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    last_d  = last_q;
    en_d    = en_q;
    out_d   = out_q;
    idx_d   = idx_q;
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
    err_d   = err_q;
`endif
    if (accept || issue_done) begin
      mask_d  = src_mask;
      valid_d = |src_mask;
      state_d = (|src_mask) ? ST_ISSUE : ST_IDLE;
      last_d  = (|src_mask) && beat_last;
      en_d    = beat_en;
      out_d   = beat_out;
      idx_d   = beat_idx;
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
      err_d   = accept && (beat_cnt > CNT_W'(N_OUT));
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      en_q    <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        out_q[j] <= '0;
        idx_q[j] <= '0;
      end
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      en_q    <= en_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // NOTE: data_q has no reset; it is only ever observed through mask_q, which is cleared.
  always_ff @(posedge i_clk) begin
    if (accept) data_q <= i_inputs;
  end

  assign o_valid   = valid_q;
  assign o_last    = last_q;
  assign o_en      = en_q;
  assign o_outputs = out_q;
  assign o_index   = idx_q;
`ifdef SPECIAL_ISSUE_MUX_ERR_EN
  assign o_error_selection = err_q;
`endif

endmodule

// File: doc/special_issue_mux.md
Name: special_issue_mux

Overview:
- Parametrised successor to the 4-to-2 special mux: routes the inputs flagged in a selection mask onto N_OUT output lanes.
- A mask with more than N_OUT bits set is not an error. The block captures the request and issues it over several output beats, lowest index first.
- It has a valid/ready handshake on both sides and sits between the operand-select logic and the downstream execution lanes.

Parameters:
- N_IN, 4, number of input channels (>=2)
- N_OUT, 2, number of output lanes (1..N_IN)
- WIDTH, 32, data width per channel
- IDX_W, max(1,$clog2(N_IN)), width of the lane index fields (derived localparam, not overridable)

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream request valid
- o_ready  out  1  block can accept a request this cycle
- i_selection  in  N_IN  request mask; bit k selects i_inputs[k]
- i_inputs  in  [N_IN-1:0] x WIDTH  input channel data, unpacked array
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the beat
- o_outputs  out  [N_OUT-1:0] x WIDTH  lane data, unpacked array
- o_en  out  N_OUT  lane k carries data
- o_index  out  [N_OUT-1:0] x IDX_W  source channel index per lane
- o_last  out  1  current beat is the final beat of the request

Behaviour:
- States: IDLE and ISSUE.
- Registers: mask_q (N_IN bits), data_q (N_IN x WIDTH), plus all outputs except o_ready, which is combinational.
- Accept condition: i_valid & o_ready. On accept, i_selection goes to mask_q and i_inputs to data_q. Inputs are ignored at all other times.
- o_ready = !i_rst & (state==IDLE | (state==ISSUE & o_valid & o_last & i_ready)). This is a combinational path from i_ready, and it is what gives back-to-back issue with no bubble.
- IDLE:
  - Accepting a non-zero mask moves to ISSUE. o_valid rises the next cycle, so latency is 1 cycle.
  - Accepting a zero mask consumes the request, stays in IDLE and produces no beat.
- Beat formation (same rule as the first beat when loaded in IDLE):
  - The lowest set bits of the remaining mask are packed into lanes 0 upward, ascending channel index.
  - Lane j gets o_outputs[j]=data_q[idx], o_index[j]=idx, o_en[j]=1.
  - Unused lanes get o_outputs=0, o_index=0, o_en=0.
  - o_en is always contiguous from lane 0.
- o_last = 1 when the remaining popcount <= N_OUT.
- ISSUE, on o_valid & i_ready:
  - The issued bits are cleared from mask_q and the next beat is formed from the remainder.
  - If o_last is set, the request is complete. With a simultaneous accept, the new request loads and its first beat appears the next cycle. Otherwise the block goes to IDLE and o_valid=0.
- Stall: while o_valid & !i_ready, every output is held bit-stable.
- Beats per request = ceil(popcount/N_OUT). With N_IN=4, N_OUT=2 the maximum is 2.
- Reset, including mid-request: the next edge forces IDLE, mask_q=0, o_valid=0, o_en=0, o_outputs=0, o_index=0, o_last=0. Unissued channels are discarded. o_ready is 0 while i_rst is high and 1 in the first cycle after it drops.

Optional Feature:
- Macro: SPECIAL_ISSUE_MUX_ERR_EN.
- Defined:
  - Adds output port o_error_selection (1 bit, registered, reset 0).
  - It is high for the whole of the first beat of any request whose popcount > N_OUT, held through stalls, and 0 on later beats.
  - This provides the legacy overflow indication without changing routing.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
All cases use N_IN=4, N_OUT=2, WIDTH=32, i_inputs[k]=32'hA0+k.
1. sel=4'b0101, i_ready=1 -> one beat one cycle after accept: o_outputs={A2,A0} (lane1,lane0), o_index={2,0}, o_en=2'b11, o_last=1; o_error_selection=0 if enabled.
2. sel=4'b1011 -> beat1: lanes {A1,A0}, o_en=11, o_last=0, o_error_selection=1. Beat2: lane0=A3, lane1=0, o_index[0]=3, o_en=01, o_last=1, o_error_selection=0.
3. sel=4'b0000 with i_valid=1 -> request consumed, o_valid stays 0, o_ready stays 1.
4. sel=4'b1111 with i_ready=0 for 3 cycles -> lanes hold {A1,A0} unchanged. After i_ready=1: beat {A3,A2} with o_last=1, then IDLE.
5. Back-to-back: sel=4'b0011, second request sel=4'b1000 held at i_valid during the last beat with i_ready=1 -> o_ready=1 that cycle, second request accepted. Next cycle lane0=A3, o_en=01, with no o_valid gap.
6. sel=4'b1111, i_rst asserted one cycle after the first beat handshake -> next cycle all outputs 0. A2/A3 are never issued. o_ready=0 during reset and 1 after.
